// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: stall-vector merge, trap/mret flush FSM and PC-redirect arbitration.
// Optional stall watchdog is built when PIPE_WDT_EN is defined.
module pipe_ctrl #(
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter int unsigned WDT_LIMIT    = 1023
) (
    input  logic        clk_i,
    input  logic        n_rst_i,
    input  logic        stallreq_if_i,
    input  logic        stallreq_id_i,
    input  logic        stallreq_ex_i,
    input  logic        stallreq_mem_i,
    input  logic        exception_i,
    input  logic [31:0] trap_vector_i,
    input  logic        mret_i,
    input  logic [31:0] mepc_i,
    input  logic        branch_req_i,
    input  logic [31:0] branch_target_i,
    output logic [5:0]  stall_o,
    output logic        flush_o,
    output logic        redirect_o,
    output logic [31:0] redirect_pc_o,
    output logic        busy_o,
    output logic        wdt_timeout_o
);

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    localparam logic [3:0] LP_CNT_INIT = 4'(FLUSH_CYCLES - 1);

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic        r_flush;
    logic        r_redirect;
    logic [31:0] r_redirect_pc;
    logic [5:0]  w_stall;
    logic        w_wdt_fire;

    // Stall vector: the deepest requesting stage freezes itself and everything upstream.
    always_comb begin
        w_stall = 6'b000000;
        if (r_state == ST_RUN) begin
            if (stallreq_mem_i) begin
                w_stall = 6'b011111;
            end else if (stallreq_ex_i) begin
                w_stall = 6'b001111;
            end else if (stallreq_id_i) begin
                w_stall = 6'b000111;
            end else if (stallreq_if_i) begin
                w_stall = 6'b000011;
            end else begin
                w_stall = 6'b000000;
            end
        end else begin
            w_stall = 6'b000000;
        end
    end

`ifdef PIPE_WDT_EN
    localparam logic [9:0] LP_WDT_LAST = 10'(WDT_LIMIT - 1);

    logic [9:0] r_wdt_cnt;
    logic       r_wdt_timeout;
    logic       w_trap_accept;

    // Fires on the WDT_LIMIT-th consecutive stalled RUN cycle.
    assign w_wdt_fire    = (r_state == ST_RUN) && (w_stall != 6'b000000) && (r_wdt_cnt >= LP_WDT_LAST);
    assign w_trap_accept = (r_state == ST_RUN) && (exception_i || mret_i || w_wdt_fire);

    // Saturating count of consecutive stalled RUN cycles; cleared on FLUSH entry.
    always_ff @(posedge clk_i or negedge n_rst_i) begin
        if (!n_rst_i) begin
            r_wdt_cnt     <= 10'd0;
            r_wdt_timeout <= 1'b0;
        end else begin
            r_wdt_timeout <= w_wdt_fire;
            if ((r_state != ST_RUN) || (w_stall == 6'b000000) || w_trap_accept) begin
                r_wdt_cnt <= 10'd0;
            end else if (r_wdt_cnt != 10'h3FF) begin
                r_wdt_cnt <= r_wdt_cnt + 10'd1;
            end else begin
                r_wdt_cnt <= r_wdt_cnt;
            end
        end
    end

    assign wdt_timeout_o = r_wdt_timeout;
`else
    assign w_wdt_fire    = 1'b0;
    assign wdt_timeout_o = 1'b0;
`endif

    // Sequencer FSM: trap/watchdog > mret > branch; redirect strobe lasts one cycle.
    always_ff @(posedge clk_i or negedge n_rst_i) begin
        if (!n_rst_i) begin
            r_state       <= ST_RUN;
            r_cnt         <= 4'd0;
            r_flush       <= 1'b0;
            r_redirect    <= 1'b0;
            r_redirect_pc <= 32'h0000_0000;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (exception_i || w_wdt_fire) begin
                        r_state       <= ST_FLUSH;
                        r_cnt         <= LP_CNT_INIT;
                        r_flush       <= 1'b1;
                        r_redirect    <= 1'b1;
                        r_redirect_pc <= trap_vector_i;
                    end else if (mret_i) begin
                        r_state       <= ST_FLUSH;
                        r_cnt         <= LP_CNT_INIT;
                        r_flush       <= 1'b1;
                        r_redirect    <= 1'b1;
                        r_redirect_pc <= mepc_i;
                    end else if (branch_req_i && !w_stall[3]) begin
                        r_redirect    <= 1'b1;
                        r_redirect_pc <= branch_target_i;
                    end else begin
                        r_redirect    <= 1'b0;
                    end
                end
                ST_FLUSH: begin
                    r_redirect <= 1'b0;
                    if (r_cnt == 4'd0) begin
                        r_state <= ST_RUN;
                        r_flush <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                default: begin
                    r_state    <= ST_RUN;
                    r_cnt      <= 4'd0;
                    r_flush    <= 1'b0;
                    r_redirect <= 1'b0;
                end
            endcase
        end
    end

    assign stall_o       = w_stall;
    assign flush_o       = r_flush;
    assign redirect_o    = r_redirect;
    assign redirect_pc_o = r_redirect_pc;
    assign busy_o        = (r_state != ST_RUN);

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Central pipeline sequencer for the 6-stage core (pc, if, id, ex, mem, wb).
- Merges per-stage stall requests into the 6-bit stall vector consumed by every inter-stage register, ex_mem included (bit3 = ex, bit4 = mem).
- Runs the trap/mret flush sequence and arbitrates the single PC-redirect port between trap entry, mret return and EX-stage branch redirects.

Parameters:
- FLUSH_CYCLES, 1, number of cycles flush_o is held during trap/mret entry (1..15).
- WDT_LIMIT, 1023, consecutive-stall-cycle limit for the watchdog (used only with PIPE_WDT_EN).

Ports:
- clk_i  input  1  clock, rising edge.
- n_rst_i  input  1  asynchronous, active-low reset.
- stallreq_if_i  input  1  fetch not ready.
- stallreq_id_i  input  1  decode hazard (load-use).
- stallreq_ex_i  input  1  multi-cycle ALU op busy.
- stallreq_mem_i  input  1  lsu waiting on bus.
- exception_i  input  1  trap request from the mem stage.
- trap_vector_i  input  32  trap target (mtvec-derived).
- mret_i  input  1  mret retiring in the mem stage.
- mepc_i  input  32  mret return address.
- branch_req_i  input  1  EX resolved a taken branch/jump.
- branch_target_i  input  32  branch target.
- stall_o  output  6  stall vector; 1 = Stop.
- flush_o  output  1  flush all inter-stage registers.
- redirect_o  output  1  one-cycle PC load strobe.
- redirect_pc_o  output  32  new PC, valid while redirect_o = 1.
- busy_o  output  1  FSM not in RUN.
- wdt_timeout_o  output  1  watchdog fired (tied 0 without PIPE_WDT_EN).

Behaviour:
- Reset (async, n_rst_i = 0):
  - state = RUN, flush counter = 0.
  - flush_o = 0, redirect_o = 0, redirect_pc_o = 0, busy_o = 0, wdt_timeout_o = 0.
- stall_o is combinational.
  - In RUN, first match wins: mem -> 6'b011111; ex -> 6'b001111; id -> 6'b000111; if -> 6'b000011; none -> 6'b000000.
  - In FLUSH, stall_o = 6'b000000.
- FSM states: RUN, FLUSH.
- RUN, evaluated at each rising edge, priority exception_i > mret_i > branch_req_i:
  - exception_i = 1:
    - Accepted even if stall_o is non-zero.
    - Next state FLUSH.
    - Next cycle: flush_o = 1, redirect_o = 1, redirect_pc_o = trap_vector_i as sampled at that edge.
    - Flush counter loads FLUSH_CYCLES-1.
  - mret_i = 1 (no exception): same sequence, target mepc_i.
  - branch_req_i = 1, no trap/mret, stall_o[3] = 0:
    - Stay in RUN.
    - Next cycle: redirect_o = 1, redirect_pc_o = branch_target_i, flush_o = 0.
    - Squashing wrong-path instructions is the branch logic's job.
  - branch_req_i = 1 with stall_o[3] = 1: not accepted. The requester holds the request until accepted.
  - A branch arriving in the same cycle as exception_i or mret_i is dropped.
- FLUSH:
  - flush_o = 1 and busy_o = 1 every cycle.
  - redirect_o = 1 only in the first FLUSH cycle; redirect_pc_o holds its value.
  - exception_i, mret_i and branch_req_i are ignored.
  - Counter decrements each cycle. When it reads 0, the next state is RUN and flush_o drops on that edge.
  - Total flush_o high time is exactly FLUSH_CYCLES cycles.
- redirect_pc_o holds its last value when redirect_o = 0.
- Reset asserted mid-FLUSH aborts immediately to the reset values; no residual redirect is issued.

Optional Feature:
- PIPE_WDT_EN: stall watchdog.
- Defined:
  - A 10-bit saturating counter increments on every RUN cycle with stall_o != 0 and clears on any cycle with stall_o = 0.
  - When the count reaches WDT_LIMIT, the block forces FLUSH exactly like an exception with target trap_vector_i, and wdt_timeout_o pulses for 1 cycle together with redirect_o.
  - The counter clears when FLUSH is entered.
- Undefined: no counter is built and wdt_timeout_o = 0.

Test Plan:
- Reset, then idle: all outputs 0 and stall_o = 6'b000000. With stallreq_id_i = 1 and stallreq_mem_i = 1 together -> stall_o = 6'b011111.
- exception_i pulse with trap_vector_i = 32'h8000_0100 and FLUSH_CYCLES = 3 -> next cycle redirect_o = 1 and redirect_pc_o = 32'h8000_0100; flush_o high for exactly 3 cycles; busy_o is 1 during the same cycles.
- exception_i, mret_i (mepc_i = 32'h0000_2000) and branch_req_i in the same cycle -> redirect_pc_o = trap_vector_i. A new mret_i during FLUSH -> ignored.
- branch_req_i held with target 32'h0000_0400 while stallreq_ex_i = 1 for 2 cycles -> no redirect while stalled; redirect_o pulses once, the cycle after stallreq_ex_i drops.
- n_rst_i asserted in the 2nd FLUSH cycle -> flush_o and redirect_o are 0 immediately; state is RUN after release.
- PIPE_WDT_EN with WDT_LIMIT = 8 and stallreq_mem_i held high -> on the 8th stalled cycle, wdt_timeout_o and redirect_o pulse for 1 cycle and flush_o rises. Same stimulus with the macro undefined -> no flush ever.
